// File: rtl/pattern_pkg.sv
// Shared definitions for the LCD test-pattern generator: display modes,
// the eight-colour bar table and a width helper for the bar index.
package pattern_pkg;

  typedef enum logic [2:0] {
    MODE_WALK   = 3'd0,
    MODE_BARS8  = 3'd1,
    MODE_RAMP   = 3'd2,
    MODE_CHECK  = 3'd3,
    MODE_GRID   = 3'd4,
    MODE_SCROLL = 3'd5,
    MODE_SOLID  = 3'd6,
    MODE_BLACK  = 3'd7
  } mode_e;

  // {r,g,b} on/off flags: white, yellow, cyan, green, magenta, red, blue, black
  localparam logic [2:0] BAR8_TABLE [8] = '{
    3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000
  };

  // Width able to hold 0..n so an over-long line cannot wrap the bar index
  function automatic int bar_width(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/pattern_gen_bar_index_acc.sv
// Divider-free bar index: a Bresenham-style accumulator that steps the bar
// counter whenever x*BAR_NUM crosses another multiple of H_ACTIVE.
module bar_index_acc #(
  parameter int H_ACTIVE = 800,
  parameter int BAR_NUM  = 16,
  parameter int BARW     = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            de,
  output logic [BARW-1:0] bar
);

  localparam int AW = $clog2(H_ACTIVE + BAR_NUM);

  // acc_q / nxt_bar_q describe the pixel after the one just presented on bar
  logic [AW-1:0]   acc_q;
  logic [BARW-1:0] nxt_bar_q;
  logic [AW-1:0]   sum;

  assign sum = acc_q + AW'(BAR_NUM);

  // Step the accumulator every active pixel, restart it in blanking
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (rst || !de) begin
      acc_q     <= '0;
      nxt_bar_q <= '0;
      bar       <= '0;
    end else begin
      bar <= nxt_bar_q;
      if (sum >= AW'(H_ACTIVE)) begin
        acc_q     <= sum - AW'(H_ACTIVE);
        nxt_bar_q <= nxt_bar_q + BARW'(1);
      end else begin
        acc_q <= sum;
      end
    end
  end

endmodule

// File: rtl/pattern_gen.sv
// Run-time selectable RGB test-pattern generator. Two pipeline stages:
// stage 1 registers timing and computes the bar index, stage 2 picks the
// colour. Mode changes and the scroll offset advance only at frame start.
module pattern_gen
  import pattern_pkg::*;
#(
  parameter int H_ACTIVE     = 800,
  parameter int V_ACTIVE     = 480,
  parameter int XW           = 10,
  parameter int YW           = 10,
  parameter int RW           = 5,
  parameter int GW           = 6,
  parameter int BW           = 5,
  parameter int BAR_NUM      = 16,
  parameter int CHECK_LOG2   = 5,
  parameter int GRID_LOG2    = 6,
  parameter int SCROLL_LOG2  = 2,
  parameter int DEFAULT_MODE = 0,
  parameter int FCW          = 16
) (
  input  logic                rgb_clk,
  input  logic                rgb_rst,
  input  logic                in_hs,
  input  logic                in_vs,
  input  logic                in_de,
  input  logic [XW-1:0]       in_x,
  input  logic [YW-1:0]       in_y,
  input  logic [2:0]          mode_sel,
  input  logic                mode_req,
  input  logic [RW+GW+BW-1:0] solid_rgb,
  output logic                out_hs,
  output logic                out_vs,
  output logic                out_de,
  output logic [RW-1:0]       out_r,
  output logic [GW-1:0]       out_g,
  output logic [BW-1:0]       out_b,
  output logic [2:0]          cur_mode,
  output logic [FCW-1:0]      frame_cnt
);

  localparam int W    = RW + GW + BW;
  localparam int BARW = bar_width(BAR_NUM);

  localparam logic [2:0]     DEF_MODE    = 3'(DEFAULT_MODE);
  localparam logic [FCW-1:0] SCROLL_MASK = FCW'((64'd1 << SCROLL_LOG2) - 64'd1);
  localparam logic [XW-1:0]  GRID_MASK_X = XW'((64'd1 << GRID_LOG2) - 64'd1);
  localparam logic [YW-1:0]  GRID_MASK_Y = YW'((64'd1 << GRID_LOG2) - 64'd1);
  localparam logic [XW-1:0]  X_LAST      = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0]  Y_LAST      = YW'(V_ACTIVE - 1);
  localparam logic [BARW:0]  BAR_NUM_W   = (BARW + 1)'(BAR_NUM);
  localparam logic [BARW-1:0] BAR_MAX    = BARW'(BAR_NUM - 1);

  // One-hot colour word with bit (W-1 - idx mod W) set, MSB = red MSB
  function automatic logic [W-1:0] walk_bit(input int idx);
    logic [W-1:0] v;
    int           pos;
    pos = W - 1 - (idx % W);
    for (int i = 0; i < W; i++) v[i] = (i == pos);
    return v;
  endfunction

  // ---------------- stage 1 ----------------
  logic            s1_hs, s1_vs, s1_de;
  logic [XW-1:0]   s1_x;
  logic [YW-1:0]   s1_y;
  logic [BARW-1:0] s1_bar;

  // Register timing and coordinates alongside the bar index
  always_ff @(posedge rgb_clk) begin
    if (rgb_rst) begin
      s1_hs <= 1'b0;
      s1_vs <= 1'b0;
      s1_de <= 1'b0;
      s1_x  <= '0;
      s1_y  <= '0;
    end else begin
      s1_hs <= in_hs;
      s1_vs <= in_vs;
      s1_de <= in_de;
      s1_x  <= in_x;
      s1_y  <= in_y;
    end
  end

  bar_index_acc #(
    .H_ACTIVE (H_ACTIVE),
    .BAR_NUM  (BAR_NUM),
    .BARW     (BARW)
  ) u_bar_acc (
    .clk (rgb_clk),
    .rst (rgb_rst),
    .de  (in_de),
    .bar (s1_bar)
  );

  // ---------------- frame control ----------------
  logic            frame_start;
  logic [FCW-1:0]  frame_nxt;
  logic            scroll_tick;
  logic [2:0]      pend_mode;
  logic [BARW-1:0] scroll_q;

  assign frame_start = in_vs & ~s1_vs;
  assign frame_nxt   = frame_cnt + FCW'(1);
  assign scroll_tick = (frame_nxt & SCROLL_MASK) == '0;

  // Latch mode requests; commit mode, frame count and scroll at frame start
  always_ff @(posedge rgb_clk) begin
    if (rgb_rst) begin
      pend_mode <= DEF_MODE;
      cur_mode  <= DEF_MODE;
      frame_cnt <= '0;
      scroll_q  <= '0;
    end else begin
      if (mode_req) pend_mode <= mode_sel;
      if (frame_start) begin
        // A request landing on the boundary cycle takes effect immediately
        cur_mode  <= mode_req ? mode_sel : pend_mode;
        frame_cnt <= frame_nxt;
        if (scroll_tick) scroll_q <= (scroll_q == BAR_MAX) ? '0 : scroll_q + BARW'(1);
      end
    end
  end

  // ---------------- stage 2 ----------------
  logic [BARW:0]   scroll_sum;
  logic [BARW-1:0] scroll_idx;
  logic [2:0]      bar8_flags;
  logic [7:0]      ramp_v;
  logic            grid_on;
  logic [W-1:0]    rgb_d;

  assign scroll_sum = {1'b0, s1_bar} + {1'b0, scroll_q};
  assign scroll_idx = (scroll_sum >= BAR_NUM_W) ? BARW'(scroll_sum - BAR_NUM_W)
                                                : BARW'(scroll_sum);
  assign bar8_flags = BAR8_TABLE[3'(s1_bar)];
  assign ramp_v     = s1_x[XW-1 -: 8];
  assign grid_on    = (s1_x == '0) || (s1_x == X_LAST) ||
                      (s1_y == '0) || (s1_y == Y_LAST) ||
                      ((s1_x & GRID_MASK_X) == '0) || ((s1_y & GRID_MASK_Y) == '0);

  // Pick the pixel colour for the current mode; blank outside active video
  always_comb begin
    // NOTE: default first so every path assigns rgb_d and no latch is inferred.
    rgb_d = '0;
    case (mode_e'(cur_mode))
      MODE_WALK:   rgb_d = walk_bit(int'(s1_bar));
      MODE_BARS8:  rgb_d = {{RW{bar8_flags[2]}}, {GW{bar8_flags[1]}}, {BW{bar8_flags[0]}}};
      MODE_RAMP:   rgb_d = {ramp_v[7 -: RW], ramp_v[7 -: GW], ramp_v[7 -: BW]};
      MODE_CHECK:  rgb_d = (s1_x[CHECK_LOG2] ^ s1_y[CHECK_LOG2]) ? '1 : '0;
      MODE_GRID:   rgb_d = grid_on ? '1 : '0;
      MODE_SCROLL: rgb_d = walk_bit(int'(scroll_idx));
      MODE_SOLID:  rgb_d = solid_rgb;
      MODE_BLACK:  rgb_d = '0;
      default:     rgb_d = '0;
    endcase
    if (!s1_de) rgb_d = '0;
  end

  // Output registers: timing and colour leave together, two cycles after input
  always_ff @(posedge rgb_clk) begin
    if (rgb_rst) begin
      out_hs <= 1'b0;
      out_vs <= 1'b0;
      out_de <= 1'b0;
      out_r  <= '0;
      out_g  <= '0;
      out_b  <= '0;
    end else begin
      out_hs                <= s1_hs;
      out_vs                <= s1_vs;
      out_de                <= s1_de;
      {out_r, out_g, out_b} <= rgb_d;
    end
  end

endmodule

// File: tb/tb_pattern_gen.sv
// Scoreboard bench for pattern_gen: one default instance (16 bars) and one
// with 7 bars share the same timing stream. Expected pixels are queued as
// stimulus is driven; a negedge monitor pops and compares on out_de.
module tb_pattern_gen;

  logic        rgb_clk = 1'b0;
  logic        rgb_rst;
  logic        in_hs, in_vs, in_de;
  logic [9:0]  in_x, in_y;
  logic [2:0]  mode_sel;
  logic        mode_req;
  logic [15:0] solid_rgb;

  logic        out_hs0, out_vs0, out_de0, out_hs1, out_vs1, out_de1;
  logic [4:0]  out_r0, out_b0, out_r1, out_b1;
  logic [5:0]  out_g0, out_g1;
  logic [2:0]  cur_mode0, cur_mode1;
  logic [15:0] frame_cnt0, frame_cnt1;
  logic [15:0] rgb0, rgb1;

  assign rgb0 = {out_r0, out_g0, out_b0};
  assign rgb1 = {out_r1, out_g1, out_b1};

  always #5 rgb_clk = ~rgb_clk;

  pattern_gen u0 (
    .rgb_clk(rgb_clk), .rgb_rst(rgb_rst), .in_hs(in_hs), .in_vs(in_vs), .in_de(in_de),
    .in_x(in_x), .in_y(in_y), .mode_sel(mode_sel), .mode_req(mode_req), .solid_rgb(solid_rgb),
    .out_hs(out_hs0), .out_vs(out_vs0), .out_de(out_de0), .out_r(out_r0), .out_g(out_g0),
    .out_b(out_b0), .cur_mode(cur_mode0), .frame_cnt(frame_cnt0)
  );

  pattern_gen #(.BAR_NUM(7)) u1 (
    .rgb_clk(rgb_clk), .rgb_rst(rgb_rst), .in_hs(in_hs), .in_vs(in_vs), .in_de(in_de),
    .in_x(in_x), .in_y(in_y), .mode_sel(mode_sel), .mode_req(mode_req), .solid_rgb(solid_rgb),
    .out_hs(out_hs1), .out_vs(out_vs1), .out_de(out_de1), .out_r(out_r1), .out_g(out_g1),
    .out_b(out_b1), .cur_mode(cur_mode1), .frame_cnt(frame_cnt1)
  );

  int errors = 0;
  int checks = 0;

  logic [15:0] q0[$];
  logic [15:0] q1[$];

  // Reference state, updated by the stimulus tasks
  int          m_cur    = 0;
  int          m_pend   = 0;
  int          m_frames = 0;
  logic [15:0] m_solid  = 16'h0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference colour for one pixel, for an instance with nbar bars on 800 px
  function automatic logic [15:0] exp_rgb(input int mode, input int x, input int y,
                                          input int nbar, input int frames,
                                          input logic [15:0] solid);
    int          bar;
    logic [15:0] top;
    logic [7:0]  v;
    logic [15:0] r;
    bar = (x * nbar) / 800;
    top = 16'h8000;
    v   = 8'(x >> 2);
    r   = 16'h0000;
    case (mode)
      0: r = top >> (bar % 16);
      1: case (bar % 8)
           0: r = 16'hFFFF;
           1: r = 16'hFFE0;
           2: r = 16'h07FF;
           3: r = 16'h07E0;
           4: r = 16'hF81F;
           5: r = 16'hF800;
           6: r = 16'h001F;
           default: r = 16'h0000;
         endcase
      2: r = {v[7:3], v[7:2], v[7:3]};
      3: r = ((((x >> 5) ^ (y >> 5)) & 1) != 0) ? 16'hFFFF : 16'h0000;
      4: r = (x == 0 || x == 799 || y == 0 || y == 479 || x % 64 == 0 || y % 64 == 0)
             ? 16'hFFFF : 16'h0000;
      5: r = top >> (((bar + frames / 4) % nbar) % 16);
      6: r = solid;
      default: r = 16'h0000;
    endcase
    return r;
  endfunction

  // Timing model: out_* is in_* two edges later, cleared by reset
  logic [2:0] p1 = 3'b000;
  logic [2:0] p2 = 3'b000;
  always @(posedge rgb_clk) begin
    if (rgb_rst) begin
      p1 <= 3'b000;
      p2 <= 3'b000;
    end else begin
      p1 <= {in_hs, in_vs, in_de};
      p2 <= p1;
    end
  end

  // Monitor: compare sync every cycle, pop a pixel whenever out_de is high
  always @(negedge rgb_clk) begin
    check("sync0", 32'({out_hs0, out_vs0, out_de0}), 32'(p2));
    check("sync1", 32'({out_hs1, out_vs1, out_de1}), 32'(p2));
    if (out_de0) begin
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pix0: got %0h, expected no pixel at %0t", rgb0, $time);
      end else check("pix0", 32'(rgb0), 32'(q0.pop_front()));
    end else check("blank0", 32'(rgb0), 32'd0);
    if (out_de1) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pix1: got %0h, expected no pixel at %0t", rgb1, $time);
      end else check("pix1", 32'(rgb1), 32'(q1.pop_front()));
    end else check("blank1", 32'(rgb1), 32'd0);
  end

  task automatic step();
    @(posedge rgb_clk);
    #1;
  endtask

  task automatic push_px(input int x, input int y);
    q0.push_back(exp_rgb(m_cur, x, y, 16, m_frames, m_solid));
    q1.push_back(exp_rgb(m_cur, x, y, 7, m_frames, m_solid));
  endtask

  task automatic check_mode(input string name);
    check({name, "_mode0"}, 32'(cur_mode0), 32'(m_cur));
    check({name, "_mode1"}, 32'(cur_mode1), 32'(m_cur));
    check({name, "_fcnt0"}, 32'(frame_cnt0), 32'(m_frames & 16'hFFFF));
    check({name, "_fcnt1"}, 32'(frame_cnt1), 32'(m_frames & 16'hFFFF));
  endtask

  // hsync pulse, short back porch, then nx active pixels of row y
  task automatic line_start(input int y, input int nx);
    for (int i = 0; i < 4; i++) begin step(); in_hs = 1'b1; in_de = 1'b0; end
    for (int i = 0; i < 2; i++) begin step(); in_hs = 1'b0; end
    for (int x = 0; x < nx; x++) begin
      step();
      in_de = 1'b1;
      in_x  = 10'(x);
      in_y  = 10'(y);
      push_px(x, y);
    end
  endtask

  task automatic drive_line(input int y, input int nx);
    line_start(y, nx);
    step(); in_de = 1'b0;
    step();
  endtask

  // Frame boundary; req_mode >= 0 also strobes a request on the rising cycle
  task automatic vsync(input int req_mode);
    step();
    in_vs = 1'b1;
    if (req_mode >= 0) begin
      mode_req = 1'b1;
      mode_sel = 3'(req_mode);
      m_pend   = req_mode;
    end
    m_cur = m_pend;
    m_frames++;
    step(); mode_req = 1'b0;
    step();
    step(); in_vs = 1'b0;
    step();
    step();
    check_mode("vsync");
  endtask

  // Mid-frame request: pending changes, displayed mode must not
  task automatic req(input int m);
    step(); mode_req = 1'b1; mode_sel = 3'(m); m_pend = m;
    step(); mode_req = 1'b0;
    step();
    check_mode("req_hold");
  endtask

  // Partial line interrupted by a one-cycle reset
  task automatic line_with_reset(input int y, input int nx);
    line_start(y, nx);
    step(); rgb_rst = 1'b1; in_x = 10'(nx);
    step();
    check("rst_de0", 32'(out_de0), 32'd0);
    check("rst_rgb0", 32'(rgb0), 32'd0);
    check("rst_rgb1", 32'(rgb1), 32'd0);
    q0.delete();
    q1.delete();
    rgb_rst  = 1'b0;
    in_de    = 1'b0;
    m_cur    = 0;
    m_pend   = 0;
    m_frames = 0;
    step();
    check_mode("after_rst");
  endtask

  initial begin
    rgb_rst = 1'b1; in_hs = 1'b0; in_vs = 1'b0; in_de = 1'b0;
    in_x = '0; in_y = '0; mode_sel = '0; mode_req = 1'b0; solid_rgb = '0;
    repeat (3) step();
    check("reset_de0", 32'(out_de0), 32'd0);
    check("reset_rgb0", 32'(rgb0), 32'd0);
    check_mode("reset");
    rgb_rst = 1'b0;

    // walking bit, 50-pixel bars on u0, 7 uneven bars on u1
    drive_line(0, 800);
    drive_line(1, 800);

    // checkerboard requested mid-frame, applied at the next frame
    req(3);
    drive_line(0, 40);
    vsync(-1);
    drive_line(0, 70);
    drive_line(32, 70);

    // two requests in one frame: the last wins
    req(2);
    drive_line(1, 20);
    req(4);
    vsync(-1);
    drive_line(5, 800);
    drive_line(0, 70);
    drive_line(479, 10);
    drive_line(64, 10);

    // grey ramp, then eight colour bars
    req(2);
    vsync(-1);
    drive_line(3, 800);
    req(1);
    vsync(-1);
    drive_line(7, 800);

    // scrolling walking bit across eight frames
    req(5);
    vsync(-1);
    for (int f = 0; f < 8; f++) begin
      drive_line(0, 60);
      vsync(-1);
    end
    drive_line(0, 60);

    // request coincident with the frame boundary
    vsync(7);
    drive_line(0, 20);

    // solid colour, then a reset pulse in the middle of a line
    m_solid   = 16'hF81F;
    solid_rgb = 16'hF81F;
    req(6);
    vsync(-1);
    drive_line(2, 100);
    line_with_reset(3, 40);
    drive_line(4, 60);

    repeat (6) step();
    check("q0_drained", 32'(q0.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
